// File: rtl/valu_slot_scheduler.sv
// ---------------------------------------------------------------------------
// valu_slot_scheduler
//   Dispatches decoded vector ALU instructions to one of SLOT_COUNT ALU slots.
//   A slot is chosen round-robin among slots that are free and flagged as
//   compatible by the instruction. Per-slot occupancy and destination register
//   are tracked so that RAW/WAW hazards against in-flight work stall issue.
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   instr_valid         decoded instruction available
//   instr_ready         scheduler accepts instr_data this cycle (comb)
//   instr_data          decoded instruction (decoded_vinstruction_t)
//   flush               abort all in-flight tracking
//   slot_done           per-slot one-cycle retire pulse
//   slot_issue_valid    registered one-hot issue pulse
//   slot_issue_data     registered issued instruction (shared by all slots)
//   slot_busy           slot occupied
//   inflight_cnt        number of occupied slots
//   err_spurious_done   sticky: retire pulse seen on an idle slot
//   err_no_slot         comb: valid instruction with no compatible slot
// ---------------------------------------------------------------------------
package rvvLitePkg;
    localparam int SLOT_COUNT      = 4;
    localparam int REGISTER_COUNT  = 32;
    localparam int ADDR_WIDTH      = 8;
    localparam int BANK_ADDR_WIDTH = 7;

    typedef struct packed {
        logic                       is_vALU;
        logic [SLOT_COUNT-1:0]      is_alu_compatible;
        logic                       uses_vs1;
        logic                       uses_vs2;
        logic                       uses_vd;
        logic                       is_widen;
        logic [5:0]                 opcode;
        logic [ADDR_WIDTH-1:0]      vd;
        logic [BANK_ADDR_WIDTH-1:0] vs1;
        logic [BANK_ADDR_WIDTH-1:0] vs2;
    } decoded_vinstruction_t;
endpackage

module valu_slot_scheduler #(
    parameter int SLOT_COUNT = rvvLitePkg::SLOT_COUNT,
    parameter int REG_IDX_W  = 5
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             instr_valid,
    output logic                                             instr_ready,
    input  logic [$bits(rvvLitePkg::decoded_vinstruction_t)-1:0] instr_data,
    input  logic                                             flush,
    input  logic [SLOT_COUNT-1:0]                            slot_done,
    output logic [SLOT_COUNT-1:0]                            slot_issue_valid,
    output logic [$bits(rvvLitePkg::decoded_vinstruction_t)-1:0] slot_issue_data,
    output logic [SLOT_COUNT-1:0]                            slot_busy,
    output logic [$clog2(SLOT_COUNT+1)-1:0]                  inflight_cnt,
    output logic                                             err_spurious_done,
    output logic                                             err_no_slot
);
    import rvvLitePkg::*;

    localparam int CNT_W   = $clog2(SLOT_COUNT + 1);
    localparam int PTR_W   = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
    localparam int INSTR_W = $bits(decoded_vinstruction_t);

    // Field extraction helpers: register numbers live in the top bits of the
    // bank-level addresses.
    function automatic logic [REG_IDX_W-1:0] vd_reg_of(input decoded_vinstruction_t d);
        return d.vd[ADDR_WIDTH-1 -: REG_IDX_W];
    endfunction

    function automatic logic [REG_IDX_W-1:0] vs1_reg_of(input decoded_vinstruction_t d);
        return d.vs1[BANK_ADDR_WIDTH-1 -: REG_IDX_W];
    endfunction

    function automatic logic [REG_IDX_W-1:0] vs2_reg_of(input decoded_vinstruction_t d);
        return d.vs2[BANK_ADDR_WIDTH-1 -: REG_IDX_W];
    endfunction

    function automatic logic [SLOT_COUNT-1:0] compat_of(input decoded_vinstruction_t d);
        return d.is_alu_compatible;
    endfunction

    function automatic logic [3:0] flags_of(input decoded_vinstruction_t d);
        return {d.uses_vs1, d.uses_vs2, d.uses_vd, d.is_widen};
    endfunction

    // A widened destination occupies an even/odd register pair, so the match
    // ignores bit 0 when the in-flight instruction was widening.
    function automatic logic reg_match(input logic [REG_IDX_W-1:0] a,
                                       input logic [REG_IDX_W-1:0] b,
                                       input logic                 wide);
        return (a == b) || (wide && (a[REG_IDX_W-1:1] == b[REG_IDX_W-1:1]));
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [SLOT_COUNT-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < SLOT_COUNT; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    decoded_vinstruction_t        instr_s;
    logic [REG_IDX_W-1:0]         in_vd_s;
    logic [REG_IDX_W-1:0]         in_vs1_s;
    logic [REG_IDX_W-1:0]         in_vs2_s;
    logic [SLOT_COUNT-1:0]        in_compat_s;
    logic [3:0]                   in_flags_s;
    logic                         in_uses_vs1_s;
    logic                         in_uses_vs2_s;
    logic                         in_uses_vd_s;
    logic                         in_widen_s;

    logic [SLOT_COUNT-1:0]        busy_r;
    logic [REG_IDX_W-1:0]         vd_reg_r [SLOT_COUNT];
    logic [SLOT_COUNT-1:0]        wide_r;
    logic [PTR_W-1:0]             rr_ptr_r;

    logic                         hazard_s;
    logic [SLOT_COUNT-1:0]        cand_s;
    logic                         grant_found_s;
    logic [PTR_W-1:0]             grant_idx_s;
    logic [SLOT_COUNT-1:0]        grant_oh_s;
    logic                         accept_s;
    logic [SLOT_COUNT-1:0]        busy_next_s;
    logic                         spurious_s;
    logic [PTR_W-1:0]             rr_next_s;

    assign instr_s       = instr_data;
    assign in_vd_s       = vd_reg_of(instr_s);
    assign in_vs1_s      = vs1_reg_of(instr_s);
    assign in_vs2_s      = vs2_reg_of(instr_s);
    assign in_compat_s   = compat_of(instr_s);
    assign in_flags_s    = flags_of(instr_s);
    assign in_uses_vs1_s = in_flags_s[3];
    assign in_uses_vs2_s = in_flags_s[2];
    assign in_uses_vd_s  = in_flags_s[1];
    assign in_widen_s    = in_flags_s[0];

    // Hazard detection against registered in-flight state only.
    always_comb begin
        hazard_s = 1'b0;
        for (int k = 0; k < SLOT_COUNT; k++) begin
            hazard_s = hazard_s | (busy_r[k] &
                ((in_uses_vs1_s & reg_match(in_vs1_s, vd_reg_r[k], wide_r[k])) |
                 (in_uses_vs2_s & reg_match(in_vs2_s, vd_reg_r[k], wide_r[k])) |
                 (in_uses_vd_s  & reg_match(in_vd_s,  vd_reg_r[k], wide_r[k]))));
        end
    end

    assign cand_s = in_compat_s & ~busy_r;

    // Round-robin grant: first candidate at or after rr_ptr, with wrap.
    always_comb begin
        int scan_idx;
        scan_idx      = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = {PTR_W{1'b0}};
        for (int i = 0; i < SLOT_COUNT; i++) begin
            scan_idx = (int'(rr_ptr_r) + i) % SLOT_COUNT;
            if (!grant_found_s && cand_s[scan_idx]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = PTR_W'(scan_idx);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign instr_ready = !flush && !hazard_s && (cand_s != {SLOT_COUNT{1'b0}});
    assign accept_s    = instr_valid && instr_ready;
    assign err_no_slot = instr_valid && (in_compat_s == {SLOT_COUNT{1'b0}});

    // One-hot grant, next busy vector, spurious retire and next pointer.
    always_comb begin
        grant_oh_s = {SLOT_COUNT{1'b0}};
        if (accept_s) begin
            grant_oh_s[grant_idx_s] = 1'b1;
        end else begin
            grant_oh_s = {SLOT_COUNT{1'b0}};
        end

        if (flush) begin
            busy_next_s = {SLOT_COUNT{1'b0}};
            spurious_s  = 1'b0;
        end else begin
            busy_next_s = (busy_r & ~slot_done) | grant_oh_s;
            spurious_s  = |(slot_done & ~busy_r & ~grant_oh_s);
        end

        if (grant_idx_s == PTR_W'(SLOT_COUNT - 1)) begin
            rr_next_s = {PTR_W{1'b0}};
        end else begin
            rr_next_s = grant_idx_s + {{(PTR_W-1){1'b0}}, 1'b1};
        end
    end

    // Slot occupancy, in-flight count and per-slot destination tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r       <= {SLOT_COUNT{1'b0}};
            wide_r       <= {SLOT_COUNT{1'b0}};
            inflight_cnt <= {CNT_W{1'b0}};
            for (int k = 0; k < SLOT_COUNT; k++) begin
                vd_reg_r[k] <= {REG_IDX_W{1'b0}};
            end
        end else begin
            busy_r       <= busy_next_s;
            inflight_cnt <= popcount(busy_next_s);
            for (int k = 0; k < SLOT_COUNT; k++) begin
                if (grant_oh_s[k]) begin
                    vd_reg_r[k] <= in_vd_s;
                    wide_r[k]   <= in_widen_s;
                end else begin
                    vd_reg_r[k] <= vd_reg_r[k];
                    wide_r[k]   <= wide_r[k];
                end
            end
        end
    end

    // Issue pulse, issued payload and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_issue_valid <= {SLOT_COUNT{1'b0}};
            slot_issue_data  <= {INSTR_W{1'b0}};
            rr_ptr_r         <= {PTR_W{1'b0}};
        end else begin
            slot_issue_valid <= grant_oh_s;
            if (accept_s) begin
                slot_issue_data <= instr_data;
                rr_ptr_r        <= rr_next_s;
            end else begin
                slot_issue_data <= slot_issue_data;
                rr_ptr_r        <= rr_ptr_r;
            end
        end
    end

    // Sticky error for retire pulses on idle slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_spurious_done <= 1'b0;
        end else begin
            err_spurious_done <= err_spurious_done | spurious_s;
        end
    end

    assign slot_busy = busy_r;

endmodule

// File: tb/tb_valu_slot_scheduler.sv
module tb_valu_slot_scheduler;
    import rvvLitePkg::*;

    localparam int W = $bits(decoded_vinstruction_t);

    logic          clk;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [W-1:0]  instr_data;
    logic          flush;
    logic [3:0]    slot_done;
    logic [3:0]    slot_issue_valid;
    logic [W-1:0]  slot_issue_data;
    logic [3:0]    slot_busy;
    logic [2:0]    inflight_cnt;
    logic          err_spurious_done;
    logic          err_no_slot;

    int checks = 0;
    int errors = 0;

    decoded_vinstruction_t first_i;
    decoded_vinstruction_t raw_i;

    valu_slot_scheduler dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr_data        (instr_data),
        .flush             (flush),
        .slot_done         (slot_done),
        .slot_issue_valid  (slot_issue_valid),
        .slot_issue_data   (slot_issue_data),
        .slot_busy         (slot_busy),
        .inflight_cnt      (inflight_cnt),
        .err_spurious_done (err_spurious_done),
        .err_no_slot       (err_no_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic decoded_vinstruction_t mk(input logic [3:0] compat, input logic [4:0] vd,
                                                 input logic [4:0] vs1, input logic [4:0] vs2,
                                                 input logic u1, input logic u2, input logic ud,
                                                 input logic wd);
        decoded_vinstruction_t d;
        d = '0;
        d.is_vALU           = 1'b1;
        d.is_alu_compatible = compat;
        d.uses_vs1          = u1;
        d.uses_vs2          = u2;
        d.uses_vd           = ud;
        d.is_widen          = wd;
        d.opcode            = 6'h15;
        d.vd                = {vd, 3'b000};
        d.vs1               = {vs1, 2'b00};
        d.vs2               = {vs2, 2'b00};
        return d;
    endfunction

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        flush       = 1'b0;
        slot_done   = 4'b0000;
        #2;
        chk("rst_issue_valid", 64'(slot_issue_valid), 64'h0);
        chk("rst_issue_data", 64'(slot_issue_data), 64'h0);
        chk("rst_busy", 64'(slot_busy), 64'h0);
        chk("rst_inflight", 64'(inflight_cnt), 64'h0);
        chk("rst_err_spurious", 64'(err_spurious_done), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_ready_compat0", 64'(instr_ready), 64'h0);
        chk("idle_no_slot", 64'(err_no_slot), 64'h0);

        // Four independent instructions back to back
        instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr_data = mk(4'b1111, 5'(i + 1), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            chk("b2b_ready", 64'(instr_ready), 64'h1);
            tick();
            chk("b2b_issue", 64'(slot_issue_valid), 64'(4'b0001 << i));
        end
        instr_data = mk(4'b1111, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("full_ready", 64'(instr_ready), 64'h0);
        chk("full_inflight", 64'(inflight_cnt), 64'h4);
        chk("full_busy", 64'(slot_busy), 64'hf);
        tick();
        chk("full_no_issue", 64'(slot_issue_valid), 64'h0);
        instr_valid = 1'b0;
        slot_done   = 4'b1111;
        tick();
        slot_done = 4'b0000;
        chk("drain_busy", 64'(slot_busy), 64'h0);
        chk("drain_inflight", 64'(inflight_cnt), 64'h0);
        chk("drain_err", 64'(err_spurious_done), 64'h0);

        // RAW hazard on v8
        first_i     = mk(4'b1111, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        instr_data  = first_i;
        instr_valid = 1'b1;
        tick();
        chk("raw_first_issue", 64'(slot_issue_valid), 64'h1);
        raw_i      = mk(4'b1111, 5'd10, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0);
        instr_data = raw_i;
        #1;
        chk("raw_stall0", 64'(instr_ready), 64'h0);
        tick();
        chk("raw_no_issue", 64'(slot_issue_valid), 64'h0);
        chk("raw_data_hold", 64'(slot_issue_data), 64'(first_i));
        chk("raw_stall1", 64'(instr_ready), 64'h0);
        slot_done = 4'b0001;
        #1;
        chk("raw_stall_done_cycle", 64'(instr_ready), 64'h0);
        tick();
        slot_done = 4'b0000;
        #1;
        chk("raw_ready_after", 64'(instr_ready), 64'h1);
        tick();
        chk("raw_issue_slot1", 64'(slot_issue_valid), 64'h2);
        chk("raw_issue_data", 64'(slot_issue_data), 64'(raw_i));
        instr_valid = 1'b0;
        slot_done   = 4'b0010;
        tick();
        slot_done = 4'b0000;
        chk("raw_clear", 64'(slot_busy), 64'h0);

        // Widening WAW: v6 wide covers v7
        instr_data  = mk(4'b1111, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        instr_valid = 1'b1;
        tick();
        chk("wide_issue_slot2", 64'(slot_issue_valid), 64'h4);
        instr_data = mk(4'b1111, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("wide_waw_stall", 64'(instr_ready), 64'h0);
        instr_data = mk(4'b1111, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("wide_v9_ready", 64'(instr_ready), 64'h1);
        tick();
        chk("wide_v9_issue", 64'(slot_issue_valid), 64'h8);
        instr_valid = 1'b0;
        slot_done   = 4'b1100;
        tick();
        slot_done = 4'b0000;
        chk("wide_clear", 64'(slot_busy), 64'h0);

        // Compatibility restricted to slot2
        instr_data  = mk(4'b0100, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        instr_valid = 1'b1;
        tick();
        chk("compat_issue_slot2", 64'(slot_issue_valid), 64'h4);
        instr_data = mk(4'b0100, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("compat_stall", 64'(instr_ready), 64'h0);
        tick();
        chk("compat_no_issue", 64'(slot_issue_valid), 64'h0);
        slot_done = 4'b0100;
        #1;
        chk("compat_stall_done", 64'(instr_ready), 64'h0);
        tick();
        slot_done = 4'b0000;
        #1;
        chk("compat_ready_n1", 64'(instr_ready), 64'h1);
        chk("compat_no_issue_n1", 64'(slot_issue_valid), 64'h0);
        tick();
        chk("compat_issue_n2", 64'(slot_issue_valid), 64'h4);
        instr_data = mk(4'b0000, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("no_slot_err", 64'(err_no_slot), 64'h1);
        chk("no_slot_ready", 64'(instr_ready), 64'h0);
        instr_valid = 1'b0;
        #1;
        chk("no_slot_err_clear", 64'(err_no_slot), 64'h0);
        slot_done = 4'b0100;
        tick();
        slot_done = 4'b0000;
        chk("compat_clear", 64'(slot_busy), 64'h0);
        chk("compat_err_spurious", 64'(err_spurious_done), 64'h0);

        // Flush with three slots busy (rr_ptr at 3)
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_data = mk(4'b1111, 5'(20 + i), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            chk("flush_fill_issue", 64'(slot_issue_valid), 64'(4'b0001 << ((3 + i) % 4)));
        end
        instr_data = mk(4'b1111, 5'd23, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("flush_pre_busy", 64'(slot_busy), 64'hb);
        chk("flush_pre_inflight", 64'(inflight_cnt), 64'h3);
        flush     = 1'b1;
        slot_done = 4'b0001;
        #1;
        chk("flush_ready", 64'(instr_ready), 64'h0);
        tick();
        flush       = 1'b0;
        slot_done   = 4'b0000;
        instr_valid = 1'b0;
        chk("flush_busy", 64'(slot_busy), 64'h0);
        chk("flush_inflight", 64'(inflight_cnt), 64'h0);
        chk("flush_no_issue", 64'(slot_issue_valid), 64'h0);
        chk("flush_err", 64'(err_spurious_done), 64'h0);
        slot_done = 4'b0010;
        tick();
        slot_done = 4'b0000;
        chk("spurious_set", 64'(err_spurious_done), 64'h1);
        tick();
        chk("spurious_sticky", 64'(err_spurious_done), 64'h1);

        // Async reset between clock edges
        instr_data  = mk(4'b1111, 5'd24, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        instr_valid = 1'b1;
        tick();
        chk("pre_areset_issue", 64'(slot_issue_valid), 64'h4);
        instr_data = mk(4'b1111, 5'd25, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_issue_valid", 64'(slot_issue_valid), 64'h0);
        chk("areset_issue_data", 64'(slot_issue_data), 64'h0);
        chk("areset_busy", 64'(slot_busy), 64'h0);
        chk("areset_inflight", 64'(inflight_cnt), 64'h0);
        chk("areset_err", 64'(err_spurious_done), 64'h0);
        instr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_release_no_issue", 64'(slot_issue_valid), 64'h0);
        instr_valid = 1'b1;
        #1;
        chk("post_release_ready", 64'(instr_ready), 64'h1);
        tick();
        chk("post_release_slot0", 64'(slot_issue_valid), 64'h1);
        instr_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/valu_slot_scheduler.md
Name: valu_slot_scheduler

Overview:
- Dispatches decoded vector ALU instructions (decoded_vinstruction_t, is_vALU=1) to one of SLOT_COUNT vector ALU slots.
- Picks a slot round-robin among slots that are free and flagged in is_alu_compatible.
- Tracks per-slot occupancy and destination register; stalls issue on RAW/WAW hazards against in-flight instructions.
- Sits between the vector decode/issue queue and the ALU slot sequencers that drive valu_req_t.

Parameters:
SLOT_COUNT, rvvLitePkg::SLOT_COUNT (4), number of ALU slots.
REG_IDX_W, 5, width of an architectural vector register number ($clog2(REGISTER_COUNT)).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  decoded instruction available
instr_ready  out  1  scheduler accepts instr_data this cycle
instr_data  in  $bits(decoded_vinstruction_t)  decoded instruction
flush  in  1  abort all in-flight tracking
slot_done  in  SLOT_COUNT  one-cycle pulse per slot: instruction retired
slot_issue_valid  out  SLOT_COUNT  one-hot issue pulse, registered
slot_issue_data  out  $bits(decoded_vinstruction_t)  issued instruction, shared by all slots, registered
slot_busy  out  SLOT_COUNT  slot occupied
inflight_cnt  out  $clog2(SLOT_COUNT+1)  popcount of slot_busy
err_spurious_done  out  1  sticky: slot_done on a non-busy slot
err_no_slot  out  1  combinational: instr_valid with is_alu_compatible==0

Behaviour:
- Reset (rst_n=0, async): slot_issue_valid=0, slot_issue_data=0, slot_busy=0, inflight_cnt=0, err_spurious_done=0, rr_ptr=0, all tracked vd=0. Reset mid-operation discards all in-flight state; no issue pulse follows deassertion.
- Register number extraction: vd_reg = vd[ADDR_WIDTH-1 -: REG_IDX_W]; vs1_reg/vs2_reg = vs1/vs2[BANK_ADDR_WIDTH-1 -: REG_IDX_W].
- Per slot k: registered busy[k], vd_reg[k], wide[k] (is_widen captured at issue).
- Hazard vs slot k (busy[k] registered value only): regs a and b match if a==b, or (wide[k] and a[4:1]==b[4:1]).
  - hazard = OR over k of busy[k] & ((uses_vs1 & match(vs1_reg)) | (uses_vs2 & match(vs2_reg)) | (uses_vd & match(vd_reg))).
- cand = is_alu_compatible & ~busy.
- Grant: first set bit of cand scanning from rr_ptr upward with wrap.
- instr_ready = !flush & !hazard & (cand != 0). Combinational, but independent of instr_valid.
- Accept = instr_valid & instr_ready at cycle N. At N+1:
  - slot_issue_valid = onehot(g) for exactly one cycle; slot_issue_data = instr_data.
  - busy[g]=1, vd_reg[g] and wide[g] captured.
  - rr_ptr = (g+1) mod SLOT_COUNT.
- No accept: slot_issue_valid=0 next cycle; slot_issue_data holds its last value.
- Throughput: one instruction per cycle while free compatible slots exist and there is no hazard.
- slot_done[k] with busy[k]=1: busy[k]=0 next cycle. A slot freed at N is grantable and hazard-free from N+1, not at N.
- slot_done[k] with busy[k]=0 and no grant to k pending: ignored; err_spurious_done set (sticky until reset).
- Simultaneous done on slot j and grant to slot g≠j: both take effect. g==j cannot occur (busy slot is not a candidate).
- flush=1: instr_ready=0 that cycle. Next cycle: busy all 0, slot_issue_valid=0, err flag and rr_ptr unchanged. slot_done during flush is ignored with no error.
- inflight_cnt is the popcount of registered busy.
- err_no_slot = instr_valid & (is_alu_compatible==0). The instruction stays stalled.

Test Plan:
- Reset, then 4 independent instrs (compat=4'b1111, vd=v1..v4, no shared regs) on back-to-back cycles → slot_issue_valid 0001, 0010, 0100, 1000 on consecutive cycles; inflight_cnt reaches 4; 5th instr sees instr_ready=0.
- RAW hazard: issue vd=v8 to slot0, then instr with uses_vs2=1, vs2=v8 → instr_ready=0 until the cycle after slot_done[0]; then issues to slot1 (rr_ptr=1).
- Widening WAW: slot holds wide vd=v6 (covers v6/v7); new instr with uses_vd, vd=v7 → stalls; new instr with vd=v9 → issues next cycle.
- Compatibility: compat=4'b0100 while slot2 busy → stall; slot_done[2] at cycle N → issue to slot2 with slot_issue_valid=0100 at N+2; compat=0 → err_no_slot=1, instr_ready=0.
- Flush: 3 slots busy, flush pulse → slot_busy=0 and inflight_cnt=0 next cycle; a later slot_done[1] sets err_spurious_done=1, which stays set.
- Async reset asserted mid-stream between clock edges → all outputs 0 immediately; first accept after release grants slot0.
